// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction (imem) and data (dmem)
// requesters using the single-phase req/gnt protocol. dmem has fixed
// priority, and a saturating wait counter promotes imem once it has lost
// arbitration too many times. A sticky flag records requester protocol
// violations: req dropped or payload changed while owning the port.
//
// state | meaning
// IDLE  | no owner, shared port quiet, arbitrating every cycle
// OWN_I | imem transfer outstanding on the shared port
// OWN_D | dmem transfer outstanding on the shared port
module mem_port_arbiter #(
  parameter int MEM_ADDR_W   = 64,
  parameter int MEM_DATA_W   = 64,
  parameter int MEM_STRB_W   = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  g_clk,
  input  logic                  g_rst,
  input  logic                  imem_req,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic                  imem_wen,
  input  logic [MEM_STRB_W-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0] imem_wdata,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,
  input  logic                  dmem_req,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,
  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } owner_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  owner_t                owner;
  owner_t                owner_nxt;
  logic [7:0]            wait_cnt;
  logic                  gnt_cycle;
  logic                  cand_i;
  logic                  cand_d;
  logic                  starve;
  logic                  viol;

  // Previous-cycle copies of both request channels for the stability check.
  logic                  i_req_q;
  logic [MEM_ADDR_W-1:0] i_addr_q;
  logic                  i_wen_q;
  logic [MEM_STRB_W-1:0] i_strb_q;
  logic [MEM_DATA_W-1:0] i_wdata_q;
  logic                  d_req_q;
  logic [MEM_ADDR_W-1:0] d_addr_q;
  logic                  d_wen_q;
  logic [MEM_STRB_W-1:0] d_strb_q;
  logic [MEM_DATA_W-1:0] d_wdata_q;

  // A gnt only completes a transfer when someone owns the port; the
  // completed requester's req still belongs to that transfer, so it sits
  // out this arbitration round.
  assign gnt_cycle = (owner != IDLE) && mem_gnt;
  assign cand_i    = imem_req && !(gnt_cycle && (owner == OWN_I));
  assign cand_d    = dmem_req && !(gnt_cycle && (owner == OWN_D));
  assign starve    = (wait_cnt >= LIMIT);

  // Owner state register.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) owner <= IDLE;
    else       owner <= owner_nxt;
  end

  // Next owner: hold while a transfer is outstanding, arbitrate otherwise.
  always_comb begin
    owner_nxt = owner;
    if ((owner == IDLE) || mem_gnt) begin
      if (cand_i && (starve || !cand_d)) owner_nxt = OWN_I;
      else if (cand_d)                   owner_nxt = OWN_D;
      else                               owner_nxt = IDLE;
    end
  end

  // Request mux and response routing to the current owner only.
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_wen    = 1'b0;
    mem_strb   = '0;
    mem_wdata  = '0;
    imem_gnt   = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = '0;
    dmem_gnt   = 1'b0;
    dmem_err   = 1'b0;
    dmem_rdata = '0;
    case (owner)
      OWN_I: begin
        mem_req    = imem_req;
        mem_addr   = imem_addr;
        mem_wen    = imem_wen;
        mem_strb   = imem_strb;
        mem_wdata  = imem_wdata;
        imem_gnt   = mem_gnt;
        imem_err   = mem_err;
        imem_rdata = mem_rdata;
      end
      OWN_D: begin
        mem_req    = dmem_req;
        mem_addr   = dmem_addr;
        mem_wen    = dmem_wen;
        mem_strb   = dmem_strb;
        mem_wdata  = dmem_wdata;
        dmem_gnt   = mem_gnt;
        dmem_err   = mem_err;
        dmem_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  // Starvation counter: counts imem's waiting cycles, cleared on its grant.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst)
      wait_cnt <= 8'd0;
    else if (imem_gnt)
      wait_cnt <= 8'd0;
    else if (imem_req && (owner != OWN_I) && (wait_cnt != 8'hFF))
      wait_cnt <= wait_cnt + 8'd1;
  end

  // Capture both request channels every cycle for the stability check.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      i_req_q   <= 1'b0;
      i_addr_q  <= '0;
      i_wen_q   <= 1'b0;
      i_strb_q  <= '0;
      i_wdata_q <= '0;
      d_req_q   <= 1'b0;
      d_addr_q  <= '0;
      d_wen_q   <= 1'b0;
      d_strb_q  <= '0;
      d_wdata_q <= '0;
    end else begin
      i_req_q   <= imem_req;
      i_addr_q  <= imem_addr;
      i_wen_q   <= imem_wen;
      i_strb_q  <= imem_strb;
      i_wdata_q <= imem_wdata;
      d_req_q   <= dmem_req;
      d_addr_q  <= dmem_addr;
      d_wen_q   <= dmem_wen;
      d_strb_q  <= dmem_strb;
      d_wdata_q <= dmem_wdata;
    end
  end

  // Violation: the owner drops req or alters its payload before gnt.
  always_comb begin
    viol = 1'b0;
    if (!mem_gnt) begin
      case (owner)
        OWN_I: viol = !imem_req || (i_req_q != imem_req) ||
                      (imem_addr != i_addr_q) || (imem_wen != i_wen_q) ||
                      (imem_strb != i_strb_q) || (imem_wdata != i_wdata_q);
        OWN_D: viol = !dmem_req || (d_req_q != dmem_req) ||
                      (dmem_addr != d_addr_q) || (dmem_wen != d_wen_q) ||
                      (dmem_strb != d_strb_q) || (dmem_wdata != d_wdata_q);
        default: viol = 1'b0;
      endcase
    end
  end

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst)     proto_err <= 1'b0;
    else if (viol) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the
// request mux / response routing, plus hand-written sequences for
// starvation promotion, protocol violation and asynchronous reset.
module tb_mem_port_arbiter;

  logic        g_clk;
  logic        g_rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_wen;
  logic [7:0]  imem_strb;
  logic [63:0] imem_wdata;
  logic        imem_gnt;
  logic        imem_err;
  logic [63:0] imem_rdata;
  logic        dmem_req;
  logic [63:0] dmem_addr;
  logic        dmem_wen;
  logic [7:0]  dmem_strb;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_err;
  logic [63:0] dmem_rdata;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_strb;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_err;
  logic [63:0] mem_rdata;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .MEM_ADDR_W(64), .MEM_DATA_W(64), .MEM_STRB_W(8), .STARVE_LIMIT(8)
  ) dut (
    .g_clk(g_clk), .g_rst(g_rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen),
    .imem_strb(imem_strb), .imem_wdata(imem_wdata),
    .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Owner encodings: 0 idle, 1 imem, 2 dmem.
  typedef struct {
    logic        ir;
    logic [63:0] ia;
    logic        dr;
    logic [63:0] da;
    logic        dwen;
    logic [7:0]  dstrb;
    logic [63:0] dwd;
    logic        gnt;
    logic        err;
    logic [63:0] rd;
    logic [1:0]  e_own;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_ig;
    logic        e_dg;
    logic        e_ie;
    logic        e_de;
    logic [63:0] e_ird;
    logic [63:0] e_drd;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge g_clk);
  endtask

  task automatic set_in(input logic ir, input logic [63:0] ia,
                        input logic dr, input logic [63:0] da,
                        input logic dwen, input logic [7:0] dstrb, input logic [63:0] dwd,
                        input logic gnt, input logic err, input logic [63:0] rd);
    imem_req   = ir;
    imem_addr  = ia;
    imem_wen   = 1'b0;
    imem_strb  = 8'h00;
    imem_wdata = 64'h0;
    dmem_req   = dr;
    dmem_addr  = da;
    dmem_wen   = dwen;
    dmem_strb  = dstrb;
    dmem_wdata = dwd;
    mem_gnt    = gnt;
    mem_err    = err;
    mem_rdata  = rd;
  endtask

  task automatic do_reset;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    g_rst = 1'b1;
    tick();
    tick();
    g_rst = 1'b0;
  endtask

  logic [1:0] own;
  logic [7:0] wc;

  initial begin
    //          ir ia          dr da        wen strb   wd        gnt err rd              own req addr        ig dg ie de ird             drd
    tbl[0]  = '{0, 64'h0,      0, 64'h0,    0,  8'h00, 64'h0,    0,  0,  64'h0,          0,  0,  64'h0,      0, 0, 0, 0, 64'h0,          64'h0};
    tbl[1]  = '{1, 64'h1000,   0, 64'h0,    0,  8'h00, 64'h0,    0,  0,  64'h0,          0,  0,  64'h0,      0, 0, 0, 0, 64'h0,          64'h0};
    tbl[2]  = '{1, 64'h1000,   0, 64'h0,    0,  8'h00, 64'h0,    0,  0,  64'h0,          1,  1,  64'h1000,   0, 0, 0, 0, 64'h0,          64'h0};
    tbl[3]  = '{1, 64'h1000,   0, 64'h0,    0,  8'h00, 64'h0,    1,  0,  64'hDEADBEEF,   1,  1,  64'h1000,   1, 0, 0, 0, 64'hDEADBEEF,   64'h0};
    tbl[4]  = '{0, 64'h0,      0, 64'h0,    0,  8'h00, 64'h0,    1,  1,  64'h55,         0,  0,  64'h0,      0, 0, 0, 0, 64'h0,          64'h0};
    tbl[5]  = '{1, 64'h2000,   1, 64'h3000, 0,  8'h00, 64'h0,    0,  0,  64'h0,          0,  0,  64'h0,      0, 0, 0, 0, 64'h0,          64'h0};
    tbl[6]  = '{1, 64'h2000,   1, 64'h3000, 0,  8'h00, 64'h0,    0,  0,  64'h0,          2,  1,  64'h3000,   0, 0, 0, 0, 64'h0,          64'h0};
    tbl[7]  = '{1, 64'h2000,   1, 64'h3000, 0,  8'h00, 64'h0,    1,  0,  64'hAA,         2,  1,  64'h3000,   0, 1, 0, 0, 64'h0,          64'hAA};
    tbl[8]  = '{1, 64'h2000,   0, 64'h0,    0,  8'h00, 64'h0,    0,  0,  64'h0,          1,  1,  64'h2000,   0, 0, 0, 0, 64'h0,          64'h0};
    tbl[9]  = '{1, 64'h2000,   0, 64'h0,    0,  8'h00, 64'h0,    1,  1,  64'h77,         1,  1,  64'h2000,   1, 0, 1, 0, 64'h77,         64'h0};
    tbl[10] = '{0, 64'h0,      0, 64'h0,    0,  8'h00, 64'h0,    0,  0,  64'h0,          0,  0,  64'h0,      0, 0, 0, 0, 64'h0,          64'h0};
    tbl[11] = '{0, 64'h0,      1, 64'h40,   1,  8'h0F, 64'h1234, 0,  0,  64'h0,          0,  0,  64'h0,      0, 0, 0, 0, 64'h0,          64'h0};
    tbl[12] = '{0, 64'h0,      1, 64'h40,   1,  8'h0F, 64'h1234, 0,  0,  64'h0,          2,  1,  64'h40,     0, 0, 0, 0, 64'h0,          64'h0};
    tbl[13] = '{0, 64'h0,      1, 64'h40,   1,  8'h0F, 64'h1234, 1,  1,  64'h0,          2,  1,  64'h40,     0, 1, 0, 1, 64'h0,          64'h0};
    tbl[14] = '{0, 64'h0,      0, 64'h0,    0,  8'h00, 64'h0,    0,  0,  64'h0,          0,  0,  64'h0,      0, 0, 0, 0, 64'h0,          64'h0};
    tbl[15] = '{0, 64'h0,      1, 64'h50,   0,  8'h00, 64'h0,    0,  0,  64'h0,          0,  0,  64'h0,      0, 0, 0, 0, 64'h0,          64'h0};
    tbl[16] = '{0, 64'h0,      1, 64'h50,   0,  8'h00, 64'h0,    0,  0,  64'h0,          2,  1,  64'h50,     0, 0, 0, 0, 64'h0,          64'h0};
    tbl[17] = '{0, 64'h0,      1, 64'h50,   0,  8'h00, 64'h0,    1,  0,  64'h11,         2,  1,  64'h50,     0, 1, 0, 0, 64'h0,          64'h11};
    tbl[18] = '{0, 64'h0,      1, 64'h50,   0,  8'h00, 64'h0,    0,  0,  64'h0,          0,  0,  64'h0,      0, 0, 0, 0, 64'h0,          64'h0};
    tbl[19] = '{0, 64'h0,      1, 64'h50,   0,  8'h00, 64'h0,    0,  0,  64'h0,          2,  1,  64'h50,     0, 0, 0, 0, 64'h0,          64'h0};
    tbl[20] = '{0, 64'h0,      1, 64'h50,   0,  8'h00, 64'h0,    1,  0,  64'h22,         2,  1,  64'h50,     0, 1, 0, 0, 64'h0,          64'h22};
    tbl[21] = '{0, 64'h0,      0, 64'h0,    0,  8'h00, 64'h0,    0,  0,  64'h0,          0,  0,  64'h0,      0, 0, 0, 0, 64'h0,          64'h0};

    g_rst = 1'b0;
    do_reset();
    at_neg();
    own = 2'(dut.owner);
    chk("reset owner", 64'(own), 64'd0);
    chk("reset wait_cnt", 64'(dut.wait_cnt), 64'd0);
    chk("reset proto_err", 64'(proto_err), 64'd0);
    chk("reset mem_req", 64'(mem_req), 64'd0);
    tick();

    // Vector table: inputs applied for one cycle, outputs checked mid-cycle.
    for (int i = 0; i < 22; i++) begin
      logic        x_wen;
      logic [7:0]  x_strb;
      logic [63:0] x_wd;
      set_in(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].da, tbl[i].dwen,
             tbl[i].dstrb, tbl[i].dwd, tbl[i].gnt, tbl[i].err, tbl[i].rd);
      x_wen  = (tbl[i].e_own == 2'd2) ? tbl[i].dwen  : 1'b0;
      x_strb = (tbl[i].e_own == 2'd2) ? tbl[i].dstrb : 8'h00;
      x_wd   = (tbl[i].e_own == 2'd2) ? tbl[i].dwd   : 64'h0;
      at_neg();
      own = 2'(dut.owner);
      chk($sformatf("row%0d owner", i),      64'(own),        64'(tbl[i].e_own));
      chk($sformatf("row%0d mem_req", i),    64'(mem_req),    64'(tbl[i].e_req));
      chk($sformatf("row%0d mem_addr", i),   mem_addr,        tbl[i].e_addr);
      chk($sformatf("row%0d mem_wen", i),    64'(mem_wen),    64'(x_wen));
      chk($sformatf("row%0d mem_strb", i),   64'(mem_strb),   64'(x_strb));
      chk($sformatf("row%0d mem_wdata", i),  mem_wdata,       x_wd);
      chk($sformatf("row%0d imem_gnt", i),   64'(imem_gnt),   64'(tbl[i].e_ig));
      chk($sformatf("row%0d dmem_gnt", i),   64'(dmem_gnt),   64'(tbl[i].e_dg));
      chk($sformatf("row%0d imem_err", i),   64'(imem_err),   64'(tbl[i].e_ie));
      chk($sformatf("row%0d dmem_err", i),   64'(dmem_err),   64'(tbl[i].e_de));
      chk($sformatf("row%0d imem_rdata", i), imem_rdata,      tbl[i].e_ird);
      chk($sformatf("row%0d dmem_rdata", i), dmem_rdata,      tbl[i].e_drd);
      tick();
    end
    at_neg();
    chk("table proto_err", 64'(proto_err), 64'd0);
    chk("table wait_cnt", 64'(dut.wait_cnt), 64'd0);
    tick();

    // Starvation, just below the limit: wait_cnt=7 in idle, dmem still wins.
    do_reset();
    set_in(1, 64'h100, 1, 64'h200, 0, 0, 0, 0, 0, 0);
    tick();
    repeat (6) tick();
    set_in(0, 64'h100, 1, 64'h200, 0, 0, 0, 1, 0, 0);
    tick();
    set_in(1, 64'h100, 1, 64'h200, 0, 0, 0, 0, 0, 0);
    at_neg();
    own = 2'(dut.owner);
    chk("starve7 idle owner", 64'(own), 64'd0);
    chk("starve7 wait_cnt", 64'(dut.wait_cnt), 64'd7);
    tick();
    at_neg();
    own = 2'(dut.owner);
    chk("starve7 winner dmem", 64'(own), 64'd2);
    chk("starve7 wait_cnt after", 64'(dut.wait_cnt), 64'd8);
    tick();

    // Starvation at the limit: wait_cnt=8 in idle, imem is promoted.
    do_reset();
    set_in(1, 64'h100, 1, 64'h200, 0, 0, 0, 0, 0, 0);
    tick();
    repeat (7) tick();
    set_in(0, 64'h100, 1, 64'h200, 0, 0, 0, 1, 0, 0);
    tick();
    set_in(1, 64'h100, 1, 64'h200, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("starve8 wait_cnt", 64'(dut.wait_cnt), 64'd8);
    tick();
    at_neg();
    own = 2'(dut.owner);
    chk("starve8 winner imem", 64'(own), 64'd1);
    chk("starve8 mem_addr", mem_addr, 64'h100);
    chk("starve8 wait_cnt after", 64'(dut.wait_cnt), 64'd9);
    tick();
    set_in(1, 64'h100, 1, 64'h200, 0, 0, 0, 1, 0, 64'h99);
    at_neg();
    chk("starve8 imem_gnt", 64'(imem_gnt), 64'd1);
    chk("starve8 dmem_gnt", 64'(dmem_gnt), 64'd0);
    tick();
    set_in(0, 64'h0, 1, 64'h200, 0, 0, 0, 0, 0, 0);
    at_neg();
    own = 2'(dut.owner);
    chk("starve8 wait_cnt cleared", 64'(dut.wait_cnt), 64'd0);
    chk("starve8 dmem owns again", 64'(own), 64'd2);
    chk("starve8 dmem addr", mem_addr, 64'h200);
    set_in(0, 64'h0, 1, 64'h200, 0, 0, 0, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Protocol violation: dmem address changes while it owns the port.
    do_reset();
    set_in(0, 0, 1, 64'h300, 0, 0, 0, 0, 0, 0);
    tick();
    at_neg();
    chk("proto before", 64'(proto_err), 64'd0);
    dmem_addr = 64'h304;
    tick();
    at_neg();
    own = 2'(dut.owner);
    chk("proto set", 64'(proto_err), 64'd1);
    chk("proto owner held", 64'(own), 64'd2);
    tick();
    at_neg();
    own = 2'(dut.owner);
    chk("proto owner still held", 64'(own), 64'd2);
    chk("proto sticky", 64'(proto_err), 64'd1);
    mem_gnt = 1'b1;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    at_neg();
    own = 2'(dut.owner);
    chk("proto owner released", 64'(own), 64'd0);
    chk("proto sticky after gnt", 64'(proto_err), 64'd1);
    tick();

    // Reset during an outstanding imem transfer.
    set_in(1, 64'h400, 1, 64'h500, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 64'h400, 1, 64'h500, 0, 0, 0, 1, 0, 0);
    tick();
    set_in(1, 64'h400, 0, 64'h0, 0, 0, 0, 0, 0, 0);
    at_neg();
    own = 2'(dut.owner);
    chk("rst pre owner", 64'(own), 64'd1);
    chk("rst pre mem_req", 64'(mem_req), 64'd1);
    chk("rst pre mem_addr", mem_addr, 64'h400);
    chk("rst pre wait_cnt", 64'(dut.wait_cnt), 64'd2);
    #1;
    g_rst = 1'b1;
    #1;
    own = 2'(dut.owner);
    chk("rst async mem_req", 64'(mem_req), 64'd0);
    chk("rst async mem_addr", mem_addr, 64'h0);
    chk("rst async owner", 64'(own), 64'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    g_rst = 1'b0;
    at_neg();
    own = 2'(dut.owner);
    chk("rst post owner", 64'(own), 64'd0);
    chk("rst post wait_cnt", 64'(dut.wait_cnt), 64'd0);
    chk("rst post proto_err", 64'(proto_err), 64'd0);
    chk("rst post mem_req", 64'(mem_req), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
